cnt_step_arb: RTL and testbench
===============================

Name: cnt_step_arb

Overview:
- Controller and arbiter for a shared external up/down counter (en/dwn step interface, value fed back).
- Two requesters each present a target value. The block grants one requester at a time, round-robin.
- While granted, it steps the counter one count per STEP_DIV cycles toward the latched target, then pulses done.
- Used to slew a shared setpoint/position count on behalf of several clients.

Parameters:
- W, 4, counter/target width in bits.
- STEP_DIV, 4, cycles between step decisions; legal range is STEP_DIV >= 3.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- req  in  2  level requests; req[i] is held until done or abort.
- tgt0  in  W  target of requester 0; sampled at grant.
- tgt1  in  W  target of requester 1; sampled at grant.
- cnt_val  in  W  current value of the external counter.
- gnt  out  2  one-hot grant, registered; at most one bit high.
- busy  out  1  high whenever gnt != 0.
- done  out  1  one-cycle pulse on completion; gnt still high in that cycle.
- cnt_en  out  1  registered one-cycle step enable to the counter.
- cnt_dwn  out  1  registered direction; valid when cnt_en=1 (1 = down).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named rst.
- Reset values: gnt=0, busy=0, done=0, cnt_en=0, cnt_dwn=0; state IDLE; div=0; round-robin pointer set so requester 0 wins next. The external counter is not reset by this block.
- Reset mid-move: outputs above are forced at the next edge. No done pulse, no further cnt_en.
- States: IDLE, MOVE, DONE.
- IDLE:
  - If any req bit is high in cycle r, gnt is set in cycle r+1.
  - Arbitration is round-robin: if both are requesting, the requester not served last wins.
  - The winner's tgt is latched to tgt_q. div is cleared. Next state is MOVE.
- MOVE: div counts 0..STEP_DIV-1, then wraps. Evaluation happens only in a cycle with div==STEP_DIV-1:
  - cnt_val==tgt_q: go to DONE.
  - Otherwise: cnt_en=1 next cycle, with cnt_dwn per the direction rule.
  - Counter updates at the end of the cnt_en cycle. STEP_DIV>=3 guarantees the next evaluation sees the new value.
- Abort: if req[owner] is low in any MOVE cycle, gnt clears next cycle and the state returns to IDLE.
  - No done pulse.
  - Any cnt_en already registered for that cycle still completes; none are issued afterwards.
  - Pointer updates as if served.
- DONE: done=1 for one cycle with gnt held. Then gnt=0, IDLE, pointer updated to the served requester.
  - Minimum of one IDLE cycle between consecutive grants.
- Latency: grant at cycle g; a move of k steps asserts done at cycle g+(k+1)*STEP_DIV. Step pulses fall at cycles g+n*STEP_DIV for n=1..k.
- Direction rule: diff = (tgt_q - cnt_val) mod 2^W, with macro behaviour below.
- Changes to tgt0/tgt1 after grant are ignored. req of the non-owner is ignored until IDLE.

Optional Feature:
- Macro: TGT_WRAP_PATH_EN.
- Defined: shortest path with wrap.
  - Up if diff < 2^(W-1).
  - Down if diff > 2^(W-1).
  - Tie (diff == 2^(W-1)) goes up.
  - The counter wraps 0<->2^W-1 as needed.
- Undefined: no wrap crossing; down if cnt_val > tgt_q (unsigned), else up.

Test Plan:
- STEP_DIV=4, cnt_val=3, req=01 with tgt0=5 at cycle r -> gnt=01 at r+1=g. cnt_en pulses at g+4 and g+8 with cnt_dwn=0. done at g+12; cnt_val=5; gnt=00 at g+13.
- Wrap, W=4, cnt_val=1, tgt0=14:
  - Macro defined -> 3 pulses, cnt_dwn=1, sequence 0,15,14.
  - Undefined -> 13 pulses, cnt_dwn=0.
  - Also with macro: cnt_val=0, tgt=8 -> cnt_dwn=0 (tie goes up).
- req=11 held from reset -> gnt=01 first, done, one IDLE cycle, then gnt=10. With req=11 still held -> gnt=01 next.
- cnt_val=7, tgt0=7 -> no cnt_en; done at g+STEP_DIV.
- req[0] dropped after the first step pulse of a 4-step move -> gnt=00 the next cycle, done never asserted, no further cnt_en.
- rst=1 at mid-move, one cycle -> next edge gnt=0, busy=0, cnt_en=0, done=0. After rst=0 with req=11 -> requester 0 is granted.

Source files
------------

// File: rtl/cnt_step_arb.sv
// ============================================================================
// Module  : cnt_step_arb
// Brief   : Round-robin arbiter that slews a shared external up/down counter
//           toward the granted requester's target, one step per STEP_DIV cycles.
//           Macro TGT_WRAP_PATH_EN selects shortest-path stepping with wrap.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module cnt_step_arb #(
  parameter int W        = 4,
  parameter int STEP_DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [W-1:0] tgt0,
  input  logic [W-1:0] tgt1,
  input  logic [W-1:0] cnt_val,
  output logic [1:0]   gnt,
  output logic         busy,
  output logic         done,
  output logic         cnt_en,
  output logic         cnt_dwn
);

  localparam int           DW       = $clog2(STEP_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [W-1:0]  tgt_q, tgt_d;
  logic [DW-1:0] div_q, div_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic          cnt_en_q, cnt_en_d;
  logic          cnt_dwn_q, cnt_dwn_d;

  logic          owner;
  logic          winner;
  logic          at_tgt;
  logic          step_dwn;

  assign owner  = gnt_q[1];
  assign at_tgt = (cnt_val == tgt_q);
  // With both requesting, the one not served last wins.
  assign winner = (req == 2'b11) ? ~last_q : req[1];

`ifdef TGT_WRAP_PATH_EN
  localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};
  logic [W-1:0] diff;
  assign diff     = tgt_q - cnt_val;
  assign step_dwn = (diff > HALF);
`else
  assign step_dwn = (cnt_val > tgt_q);
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    tgt_d     = tgt_q;
    div_d     = div_q;
    last_d    = last_q;
    done_d    = 1'b0;
    cnt_en_d  = 1'b0;
    cnt_dwn_d = cnt_dwn_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d   = winner ? 2'b10 : 2'b01;
          tgt_d   = winner ? tgt1 : tgt0;
          div_d   = '0;
          state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        if (!req[owner]) begin
          gnt_d   = 2'b00;
          last_d  = owner;
          state_d = S_IDLE;
        end else if (div_q == DIV_LAST) begin
          if (at_tgt) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_en_d  = 1'b1;
            cnt_dwn_d = step_dwn;
          end
        end
      end
      S_DONE: begin
        gnt_d   = 2'b00;
        last_d  = owner;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= 2'b00;
      tgt_q     <= '0;
      div_q     <= '0;
      last_q    <= 1'b1;
      done_q    <= 1'b0;
      cnt_en_q  <= 1'b0;
      cnt_dwn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      tgt_q     <= tgt_d;
      div_q     <= div_d;
      last_q    <= last_d;
      done_q    <= done_d;
      cnt_en_q  <= cnt_en_d;
      cnt_dwn_q <= cnt_dwn_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = |gnt_q;
  assign done    = done_q;
  assign cnt_en  = cnt_en_q;
  assign cnt_dwn = cnt_dwn_q;

endmodule

`default_nettype wire

// File: tb/tb_cnt_step_arb.sv
// ============================================================================
// Module  : tb_cnt_step_arb
// Brief   : Directed testbench for cnt_step_arb with an external counter model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cnt_step_arb;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [3:0] tgt0;
  logic [3:0] tgt1;
  logic [3:0] cnt_val;
  logic [1:0] gnt;
  logic       busy;
  logic       done;
  logic       cnt_en;
  logic       cnt_dwn;

  logic       load_en;
  logic [3:0] load_val;

  int checks;
  int errors;

  cnt_step_arb #(.W(4), .STEP_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .tgt0    (tgt0),
    .tgt1    (tgt1),
    .cnt_val (cnt_val),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .cnt_en  (cnt_en),
    .cnt_dwn (cnt_dwn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External up/down counter, wrapping naturally at 4 bits.
  always @(posedge clk) begin
    if (load_en)
      cnt_val <= load_val;
    else if (cnt_en)
      cnt_val <= cnt_dwn ? cnt_val - 4'd1 : cnt_val + 4'd1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_cnt(input logic [3:0] v);
    load_val = v;
    load_en  = 1'b1;
    tick();
    load_en  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req = 2'b00;
    tick();
    tick();
    checks++;
    if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++;
    if (cnt_en !== 1'b0) begin errors++; $display("FAIL reset_cnt_en got=%b exp=0", cnt_en); end
    checks++;
    if (cnt_dwn !== 1'b0) begin errors++; $display("FAIL reset_cnt_dwn got=%b exp=0", cnt_dwn); end
    rst = 1'b0;
    tick();
  endtask

  // Full move for one requester, checking every cycle from grant to release.
  task automatic test_move(input string name, input int who, input logic [3:0] start,
                           input logic [3:0] tgt, input int k, input logic exp_dwn,
                           input logic [3:0] fin);
    logic [1:0] exp_g;
    logic       exp_en;
    logic       exp_done;
    exp_g = (who == 1) ? 2'b10 : 2'b01;
    load_cnt(start);
    tgt0 = tgt;
    tgt1 = tgt;
    req  = exp_g;
    tick();
    checks++;
    if (gnt !== exp_g || busy !== 1'b1) begin
      errors++; $display("FAIL %s_grant got gnt=%b busy=%b exp gnt=%b busy=1", name, gnt, busy, exp_g);
    end
    // Targets changed after grant must not matter.
    tgt0 = ~tgt;
    tgt1 = ~tgt;
    for (int c = 1; c <= (k + 1) * 4; c++) begin
      tick();
      exp_en   = ((c % 4) == 0) && (c <= k * 4);
      exp_done = (c == (k + 1) * 4);
      checks++;
      if (cnt_en !== exp_en || done !== exp_done) begin
        errors++;
        $display("FAIL %s_cycle%0d got en=%b done=%b exp en=%b done=%b", name, c, cnt_en, done, exp_en, exp_done);
      end
      if (exp_en) begin
        checks++;
        if (cnt_dwn !== exp_dwn) begin
          errors++; $display("FAIL %s_dir_cycle%0d got=%b exp=%b", name, c, cnt_dwn, exp_dwn);
        end
      end
      if (exp_done) begin
        checks++;
        if (gnt !== exp_g) begin
          errors++; $display("FAIL %s_gnt_at_done got=%b exp=%b", name, gnt, exp_g);
        end
      end
    end
    req = 2'b00;
    tick();
    checks++;
    if (gnt !== 2'b00 || done !== 1'b0) begin
      errors++; $display("FAIL %s_release got gnt=%b done=%b exp gnt=00 done=0", name, gnt, done);
    end
    checks++;
    if (cnt_val !== fin) begin
      errors++; $display("FAIL %s_final_cnt got=%0d exp=%0d", name, cnt_val, fin);
    end
  endtask

  task automatic test_wrap;
`ifdef TGT_WRAP_PATH_EN
    test_move("wrap", 0, 4'd1, 4'd14, 3, 1'b1, 4'd14);
`else
    test_move("wrap", 0, 4'd1, 4'd14, 13, 1'b0, 4'd14);
`endif
    test_move("tie", 0, 4'd0, 4'd8, 8, 1'b0, 4'd8);
  endtask

  task automatic test_back_to_back;
    rst = 1'b1;
    load_cnt(4'd5);
    tgt0 = 4'd5;
    tgt1 = 4'd5;
    req  = 2'b11;
    rst  = 1'b0;
    tick();
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL rr_first got=%b exp=01", gnt); end
    tick(); tick(); tick(); tick();
    checks++;
    if (done !== 1'b1 || gnt !== 2'b01) begin
      errors++; $display("FAIL rr_done0 got done=%b gnt=%b exp done=1 gnt=01", done, gnt);
    end
    tick();
    checks++;
    if (gnt !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("FAIL rr_idle_gap got gnt=%b busy=%b exp gnt=00 busy=0", gnt, busy);
    end
    tick();
    checks++;
    if (gnt !== 2'b10) begin errors++; $display("FAIL rr_second got=%b exp=10", gnt); end
    tick(); tick(); tick(); tick();
    checks++;
    if (done !== 1'b1 || gnt !== 2'b10) begin
      errors++; $display("FAIL rr_done1 got done=%b gnt=%b exp done=1 gnt=10", done, gnt);
    end
    tick();
    checks++;
    if (gnt !== 2'b00) begin errors++; $display("FAIL rr_idle_gap2 got=%b exp=00", gnt); end
    tick();
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL rr_third got=%b exp=01", gnt); end
    req = 2'b00;
    tick();
    checks++;
    if (gnt !== 2'b00) begin errors++; $display("FAIL rr_abort_release got=%b exp=00", gnt); end
    tick();
  endtask

  task automatic test_abort;
    int bad_en;
    int bad_done;
    bad_en   = 0;
    bad_done = 0;
    load_cnt(4'd0);
    tgt0 = 4'd4;
    req  = 2'b01;
    tick();
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL abort_grant got=%b exp=01", gnt); end
    tick(); tick(); tick(); tick();
    checks++;
    if (cnt_en !== 1'b1 || cnt_dwn !== 1'b0) begin
      errors++; $display("FAIL abort_first_step got en=%b dwn=%b exp en=1 dwn=0", cnt_en, cnt_dwn);
    end
    req = 2'b00;
    tick();
    checks++;
    if (gnt !== 2'b00 || done !== 1'b0 || cnt_en !== 1'b0) begin
      errors++; $display("FAIL abort_release got gnt=%b done=%b en=%b exp 00/0/0", gnt, done, cnt_en);
    end
    for (int c = 0; c < 12; c++) begin
      tick();
      if (cnt_en !== 1'b0) bad_en++;
      if (done !== 1'b0) bad_done++;
    end
    checks++;
    if (bad_en != 0 || bad_done != 0) begin
      errors++; $display("FAIL abort_quiet got en_cycles=%0d done_cycles=%0d exp 0/0", bad_en, bad_done);
    end
    checks++;
    if (cnt_val !== 4'd1) begin errors++; $display("FAIL abort_cnt got=%0d exp=1", cnt_val); end
  endtask

  task automatic test_reset_mid;
    load_cnt(4'd0);
    tgt1 = 4'd4;
    req  = 2'b10;
    tick();
    checks++;
    if (gnt !== 2'b10) begin errors++; $display("FAIL rstmid_grant got=%b exp=10", gnt); end
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    checks++;
    if (gnt !== 2'b00 || busy !== 1'b0 || cnt_en !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs got gnt=%b busy=%b en=%b done=%b exp 00/0/0/0", gnt, busy, cnt_en, done);
    end
    rst = 1'b0;
    req = 2'b11;
    tick();
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL rstmid_regrant got=%b exp=01", gnt); end
    req = 2'b00;
    tick();
    tick();
    checks++;
    if (cnt_val !== 4'd0) begin errors++; $display("FAIL rstmid_cnt got=%0d exp=0", cnt_val); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    req      = 2'b00;
    tgt0     = 4'd0;
    tgt1     = 4'd0;
    load_en  = 1'b0;
    load_val = 4'd0;
    test_reset();
    test_move("up2", 0, 4'd3, 4'd5, 2, 1'b0, 4'd5);
    test_move("down3_req1", 1, 4'd9, 4'd6, 3, 1'b1, 4'd6);
    test_move("zero", 0, 4'd7, 4'd7, 0, 1'b0, 4'd7);
    test_wrap();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
